// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
// This file holds the opcode constants, the FSM state encodings, the ALU
// operation codes and the encodings of the datapath select signals.
// The control unit top and the ALU decoder both import it.
package riscv_ctrl_pkg;

  // Main FSM states. The numeric values are visible on the debug output.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BEQ       = 4'd9,
    S_JAL       = 4'd10,
    S_TRAP      = 4'd11
  } state_e;

  // Major opcodes of the supported instructions.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // funct3 values that the datapath implements.
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  // ALU operation codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Result mux select.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU A operand select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B operand select.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Memory address select.
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder for the multicycle control unit.
// Maps the instruction funct fields to an ALU operation and flags funct3
// values the datapath does not implement.
// Ports:
//   funct3        in  instruction [14:12]
//   funct7_5      in  instruction [30], selects sub for R-type funct3=000
//   is_rtype      in  1 when the instruction is register-register
//   alu_control   out ALU operation code
//   funct_illegal out 1 when funct3 is not an implemented operation
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  // funct7_5 only matters for R-type: for I-type that bit belongs to the
  // immediate, so addi must always add.
  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct3)
      F3_ADD_SUB: alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
      F3_AND:     alu_control = ALU_AND;
      F3_OR:      alu_control = ALU_OR;
      F3_XOR:     alu_control = ALU_XOR;
      F3_SLT:     alu_control = ALU_SLT;
      default:    funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multicycle RV32I datapath.
// Sequences one instruction at a time (lw, sw, R-type, I-type, beq, jal)
// over a shared instruction/data memory with a mem_ready handshake.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   opcode, funct3,       fields of the instruction register
//   funct7_5
//   zero                  ALU zero flag, used by beq
//   mem_ready             memory completes the requested access this cycle
//   pc_write, ir_write    PC load, instruction/old-PC register load
//   adr_src               memory address select (PC or ALUOut)
//   mem_read, mem_write   memory strobes
//   reg_write             register file write enable
//   result_src            result mux select
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_control           ALU operation
//   instr_done            one-cycle pulse when an instruction retires
//   illegal_instr         high while trapped
//   state                 current FSM state for debug
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int STATE_W         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               adr_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic               instr_done,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state
);

  state_e state_q;
  state_e state_d;

  logic [2:0] dec_alu_control;
  logic       dec_funct_illegal;
  logic       is_rtype;

  // Unregistered versions of every output; the real outputs are these
  // gated by rst_n so nothing is requested while reset is held.
  logic       pc_write_c;
  logic       ir_write_c;
  logic       adr_src_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic       reg_write_c;
  logic [1:0] result_src_c;
  logic [1:0] alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [2:0] alu_control_c;
  logic       instr_done_c;
  logic       illegal_instr_c;

  // Where an unsupported instruction goes: a sticky trap, or silently back
  // to fetch so it behaves as a NOP.
  localparam state_e ILLEGAL_TARGET = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

  assign is_rtype = (opcode == OP_RTYPE);

  // The decoder is driven straight from the instruction register, so the
  // same instance serves the legality check in DECODE and the operation
  // select in EXEC_R / EXEC_I.
  alu_decoder u_alu_decoder (
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .is_rtype      (is_rtype),
    .alu_control   (dec_alu_control),
    .funct_illegal (dec_funct_illegal)
  );

  // State register; reset returns to FETCH immediately, abandoning any
  // instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. Everything defaults to inactive and each
  // state raises only what it needs.
  always_comb begin
    state_d         = state_q;
    pc_write_c      = 1'b0;
    ir_write_c      = 1'b0;
    adr_src_c       = ADR_PC;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    reg_write_c     = 1'b0;
    result_src_c    = RES_ALUOUT;
    alu_src_a_c     = SRCA_PC;
    alu_src_b_c     = SRCB_RS2;
    alu_control_c   = ALU_ADD;
    instr_done_c    = 1'b0;
    illegal_instr_c = 1'b0;

    case (state_q)
      // Read the instruction at PC and compute PC+4 in the same cycle; the
      // PC and IR only load once memory delivers.
      S_FETCH: begin
        adr_src_c    = ADR_PC;
        mem_read_c   = 1'b1;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_FOUR;
        alu_control_c = ALU_ADD;
        result_src_c = RES_ALURESULT;
        pc_write_c   = mem_ready;
        ir_write_c   = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end
      end

      // Old PC + immediate lands in ALUOut so BEQ and JAL find their
      // target ready.
      S_DECODE: begin
        alu_src_a_c   = SRCA_OLDPC;
        alu_src_b_c   = SRCB_IMM;
        alu_control_c = ALU_ADD;
        case (opcode)
          OP_LOAD,
          OP_STORE:  state_d = S_MEM_ADR;
          OP_RTYPE:  state_d = dec_funct_illegal ? ILLEGAL_TARGET : S_EXEC_R;
          OP_ITYPE:  state_d = dec_funct_illegal ? ILLEGAL_TARGET : S_EXEC_I;
          OP_BRANCH: state_d = (funct3 == F3_BEQ) ? S_BEQ : ILLEGAL_TARGET;
          OP_JAL:    state_d = S_JAL;
          default:   state_d = ILLEGAL_TARGET;
        endcase
      end

      S_MEM_ADR: begin
        alu_src_a_c   = SRCA_RS1;
        alu_src_b_c   = SRCB_IMM;
        alu_control_c = ALU_ADD;
        state_d       = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        adr_src_c  = ADR_ALUOUT;
        mem_read_c = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        result_src_c = RES_MEMDATA;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end

      // A store retires in the cycle memory accepts it; there is no
      // separate writeback.
      S_MEM_WRITE: begin
        adr_src_c   = ADR_ALUOUT;
        mem_write_c = 1'b1;
        if (mem_ready) begin
          instr_done_c = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_EXEC_R: begin
        alu_src_a_c   = SRCA_RS1;
        alu_src_b_c   = SRCB_RS2;
        alu_control_c = dec_alu_control;
        state_d       = S_ALU_WB;
      end

      S_EXEC_I: begin
        alu_src_a_c   = SRCA_RS1;
        alu_src_b_c   = SRCB_IMM;
        alu_control_c = dec_alu_control;
        state_d       = S_ALU_WB;
      end

      S_ALU_WB: begin
        result_src_c = RES_ALUOUT;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end

      // rs1 - rs2 sets zero; the branch target already sits in ALUOut.
      S_BEQ: begin
        alu_src_a_c   = SRCA_RS1;
        alu_src_b_c   = SRCB_RS2;
        alu_control_c = ALU_SUB;
        result_src_c  = RES_ALUOUT;
        pc_write_c    = zero;
        instr_done_c  = 1'b1;
        state_d       = S_FETCH;
      end

      // PC takes the target from ALUOut while the ALU forms old PC + 4,
      // which ALU_WB then writes into rd.
      S_JAL: begin
        alu_src_a_c   = SRCA_OLDPC;
        alu_src_b_c   = SRCB_FOUR;
        alu_control_c = ALU_ADD;
        result_src_c  = RES_ALUOUT;
        pc_write_c    = 1'b1;
        state_d       = S_ALU_WB;
      end

      S_TRAP: begin
        illegal_instr_c = 1'b1;
        state_d         = S_TRAP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Holding rst_n low must also silence the outputs of the FETCH state the
  // register is parked in.
  assign pc_write      = rst_n & pc_write_c;
  assign ir_write      = rst_n & ir_write_c;
  assign adr_src       = rst_n & adr_src_c;
  assign mem_read      = rst_n & mem_read_c;
  assign mem_write     = rst_n & mem_write_c;
  assign reg_write     = rst_n & reg_write_c;
  assign instr_done    = rst_n & instr_done_c;
  assign illegal_instr = rst_n & illegal_instr_c;
  assign result_src    = rst_n ? result_src_c  : 2'b00;
  assign alu_src_a     = rst_n ? alu_src_a_c   : 2'b00;
  assign alu_src_b     = rst_n ? alu_src_b_c   : 2'b00;
  assign alu_control   = rst_n ? alu_control_c : 3'b000;
  assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit.
// Two instances share all inputs: the main one traps on illegal
// instructions, the second treats them as NOPs.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;

  logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  logic       instr_done, illegal_instr;
  logic [3:0] state;

  logic       nt_pc_write, nt_ir_write, nt_adr_src, nt_mem_read, nt_mem_write, nt_reg_write;
  logic [1:0] nt_result_src, nt_alu_src_a, nt_alu_src_b;
  logic [2:0] nt_alu_control;
  logic       nt_instr_done, nt_illegal_instr;
  logic [3:0] nt_state;

  int checks   = 0;
  int failures = 0;

  multicycle_control_unit #(.TRAP_ON_ILLEGAL(1'b1), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .instr_done(instr_done), .illegal_instr(illegal_instr),
    .state(state)
  );

  multicycle_control_unit #(.TRAP_ON_ILLEGAL(1'b0), .STATE_W(4)) dut_nt (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(nt_pc_write), .ir_write(nt_ir_write),
    .adr_src(nt_adr_src), .mem_read(nt_mem_read), .mem_write(nt_mem_write),
    .reg_write(nt_reg_write), .result_src(nt_result_src), .alu_src_a(nt_alu_src_a),
    .alu_src_b(nt_alu_src_b), .alu_control(nt_alu_control), .instr_done(nt_instr_done),
    .illegal_instr(nt_illegal_instr), .state(nt_state)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge and let outputs settle.
  task automatic step(input logic rdy, input logic z);
    @(negedge clk);
    mem_ready = rdy;
    zero      = z;
    #1;
  endtask

  // Assert reset, then release with FETCH parked (mem_ready low).
  task automatic reset_and_release();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || illegal_instr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_clear state=%0d illegal=%0b exp state=0 illegal=0", state, illegal_instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || {pc_write, ir_write, mem_read, mem_write, reg_write, instr_done} !== 6'b0
        || alu_src_b !== 2'b00 || result_src !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_hold state=%0d en=%b srcb=%b res=%b exp 0/000000/00/00", state,
               {pc_write, ir_write, mem_read, mem_write, reg_write, instr_done}, alu_src_b, result_src);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (pc_write !== 1'b1 || ir_write !== 1'b1 || alu_src_b !== 2'b10 || mem_read !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fetch_after_reset pc_w=%b ir_w=%b srcb=%b mrd=%b exp 1 1 10 1",
               pc_write, ir_write, alu_src_b, mem_read);
    end
    step(1'b1, 1'b0);
    checks++;
    if (state !== 4'd1) begin
      failures++;
      $display("[TB] FAIL reach_decode state=%0d exp=1", state);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || {pc_write, ir_write, mem_read, mem_write, reg_write, instr_done} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_decode state=%0d en=%b exp 0/000000", state,
               {pc_write, ir_write, mem_read, mem_write, reg_write, instr_done});
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic test_rtype(input logic f7, input logic [2:0] exp_alu);
    logic [3:0] exp_st [4];
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd8};
    opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = f7;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (state !== exp_st[i] || reg_write !== (i == 3) || instr_done !== (i == 3)) begin
        failures++;
        $display("[TB] FAIL rtype_f7%0b[%0d] state=%0d rw=%b done=%b exp %0d %b %b", f7, i,
                 state, reg_write, instr_done, exp_st[i], (i == 3), (i == 3));
      end
      if (i == 2) begin
        checks++;
        if (alu_control !== exp_alu || alu_src_a !== 2'b10 || alu_src_b !== 2'b00) begin
          failures++;
          $display("[TB] FAIL rtype_exec_f7%0b alu=%b a=%b b=%b exp %b 10 00", f7, alu_control,
                   alu_src_a, alu_src_b, exp_alu);
        end
      end
    end
  endtask

  task automatic test_itype_xor();
    logic [3:0] exp_st [4];
    exp_st = '{4'd0, 4'd1, 4'd7, 4'd8};
    opcode = 7'b0010011; funct3 = 3'b100; funct7_5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (state !== exp_st[i]) begin
        failures++;
        $display("[TB] FAIL itype_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]);
      end
      if (i == 2) begin
        checks++;
        if (alu_control !== 3'b100 || alu_src_b !== 2'b01) begin
          failures++;
          $display("[TB] FAIL itype_exec alu=%b b=%b exp 100 01", alu_control, alu_src_b);
        end
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] exp_st [8];
    logic       rdy    [8];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    rdy    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(rdy[i], 1'b0);
      checks++;
      if (state !== exp_st[i]) begin
        failures++;
        $display("[TB] FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]);
      end
      if (i >= 3 && i <= 6) begin
        checks++;
        if (adr_src !== 1'b1 || mem_read !== 1'b1 || reg_write !== 1'b0) begin
          failures++;
          $display("[TB] FAIL lw_memread[%0d] adr=%b mrd=%b rw=%b exp 1 1 0", i, adr_src, mem_read, reg_write);
        end
      end
      if (i == 7) begin
        checks++;
        if (result_src !== 2'b01 || reg_write !== 1'b1 || instr_done !== 1'b1) begin
          failures++;
          $display("[TB] FAIL lw_wb res=%b rw=%b done=%b exp 01 1 1", result_src, reg_write, instr_done);
        end
      end
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [5];
    logic       rdy    [5];
    exp_st = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5};
    rdy    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(rdy[i], 1'b0);
      checks++;
      if (state !== exp_st[i] || mem_write !== (i == 4) || reg_write !== 1'b0
          || (mem_read & mem_write) !== 1'b0 || instr_done !== (i == 4)) begin
        failures++;
        $display("[TB] FAIL sw[%0d] state=%0d mwr=%b rw=%b mrd=%b done=%b exp %0d %b 0 - %b", i,
                 state, mem_write, reg_write, mem_read, instr_done, exp_st[i], (i == 4), (i == 4));
      end
      if (i == 0) begin
        checks++;
        if (pc_write !== 1'b0 || ir_write !== 1'b0) begin
          failures++;
          $display("[TB] FAIL sw_fetch_wait pc_w=%b ir_w=%b exp 0 0", pc_write, ir_write);
        end
      end
    end
  endtask

  task automatic test_beq(input logic z, input logic exp_pcw);
    logic [3:0] exp_st [3];
    exp_st = '{4'd0, 4'd1, 4'd9};
    opcode = 7'b1100011; funct3 = 3'b000; funct7_5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 2) ? z : 1'b0);
      checks++;
      if (state !== exp_st[i]) begin
        failures++;
        $display("[TB] FAIL beq_z%0b_state[%0d] got=%0d exp=%0d", z, i, state, exp_st[i]);
      end
    end
    checks++;
    if (pc_write !== exp_pcw || alu_control !== 3'b001 || instr_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL beq_z%0b pc_w=%b alu=%b done=%b exp %b 001 1", z, pc_write,
               alu_control, instr_done, exp_pcw);
    end
  endtask

  task automatic test_jal();
    logic [3:0] exp_st [4];
    exp_st = '{4'd0, 4'd1, 4'd10, 4'd8};
    opcode = 7'b1101111; funct3 = 3'b000; funct7_5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (state !== exp_st[i]) begin
        failures++;
        $display("[TB] FAIL jal_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]);
      end
      if (i == 2) begin
        checks++;
        if (pc_write !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10 || reg_write !== 1'b0) begin
          failures++;
          $display("[TB] FAIL jal_exec pc_w=%b a=%b b=%b rw=%b exp 1 01 10 0", pc_write,
                   alu_src_a, alu_src_b, reg_write);
        end
      end
      if (i == 3) begin
        checks++;
        if (reg_write !== 1'b1 || result_src !== 2'b00) begin
          failures++;
          $display("[TB] FAIL jal_wb rw=%b res=%b exp 1 00", reg_write, result_src);
        end
      end
    end
  endtask

  task automatic test_illegal(input logic [6:0] op, input logic [2:0] f3, input int hold);
    opcode = op; funct3 = f3; funct7_5 = 1'b0;
    for (int i = 0; i < 2 + hold; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (i < 2) begin
        if (state !== i[3:0]) begin
          failures++;
          $display("[TB] FAIL illegal_%b_pre[%0d] state=%0d exp=%0d", op, i, state, i);
        end
      end else if (state !== 4'd11 || illegal_instr !== 1'b1
                   || {pc_write, ir_write, mem_read, mem_write, reg_write, instr_done} !== 6'b0) begin
        failures++;
        $display("[TB] FAIL illegal_%b_trap[%0d] state=%0d ill=%b en=%b exp 11 1 000000", op, i,
                 state, illegal_instr, {pc_write, ir_write, mem_read, mem_write, reg_write, instr_done});
      end
      checks++;
      if (nt_reg_write !== 1'b0 || nt_mem_write !== 1'b0 || nt_illegal_instr !== 1'b0
          || (i == 2 && nt_state !== 4'd0)) begin
        failures++;
        $display("[TB] FAIL illegal_%b_nop[%0d] state=%0d rw=%b mwr=%b ill=%b exp no writes", op, i,
                 nt_state, nt_reg_write, nt_mem_write, nt_illegal_instr);
      end
    end
    reset_and_release();
  endtask

  initial begin
    $display("[TB] starting multicycle_control_unit bench");
    test_reset();
    test_rtype(1'b0, 3'b000);
    test_rtype(1'b1, 3'b001);
    test_itype_xor();
    test_lw_wait();
    test_sw();
    test_beq(1'b1, 1'b1);
    test_beq(1'b0, 1'b0);
    test_jal();
    test_illegal(7'b1111111, 3'b000, 20);
    test_illegal(7'b0110011, 3'b001, 5);
    test_rtype(1'b0, 3'b000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main FSM that sequences the multicycle RV32I datapath inside `processador`.
- Drives every register enable, mux select and memory strobe, one instruction at a time, over a shared instruction/data memory.
- Memory access uses a `mem_ready` handshake, so wait states are supported.
- Supported subset: lw, sw, R-type ALU, I-type ALU, beq, jal.

Parameters:
- TRAP_ON_ILLEGAL, 1, 1: illegal instruction enters TRAP and stays there until reset; 0: illegal instruction is treated as NOP and returns to FETCH.
- STATE_W, 4, width of the `state` debug output.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction register [6:0].
- funct3  in  3  instruction register [14:12].
- funct7_5  in  1  instruction register [30].
- zero  in  1  ALU zero flag, combinational from the current ALU operation.
- mem_ready  in  1  memory completes the requested access this cycle.
- pc_write  out  1  PC register load.
- ir_write  out  1  instruction register and old-PC register load.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- result_src  out  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- alu_src_a  out  2  ALU A operand: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  out  2  ALU B operand: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_instr  out  1  high while in TRAP.
- state  out  STATE_W  current state, for debug.

Behaviour:
- State register:
  - Reset is asynchronous: `rst_n` low forces state = FETCH (0).
  - While `rst_n` is low, the enables `pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write` and `instr_done` are forced to 0.
  - While `rst_n` is low, all selects read 0.
- Outputs are combinational from state, plus `mem_ready` and `zero` where noted.
- Any output not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BEQ 9, JAL 10, TRAP 11.
- Per-state outputs and transitions:
  - FETCH:
    - Outputs: adr_src=0, mem_read=1, a=00, b=10, add, result_src=10.
    - `pc_write` = `ir_write` = `mem_ready`.
    - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
  - DECODE:
    - Outputs: a=01, b=01, add, so ALUOut becomes the branch/jump target.
    - Next state by opcode: 0000011 → MEM_ADR; 0100011 → MEM_ADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 with funct3=000 → BEQ; 1101111 → JAL.
    - Anything else → TRAP, or FETCH when TRAP_ON_ILLEGAL=0.
    - R-type and I-type with funct3 ∈ {001, 011, 101} are illegal.
  - MEM_ADR:
    - Outputs: a=10, b=01, add.
    - Next state: MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ:
    - Outputs: adr_src=1, mem_read=1.
    - Holds until `mem_ready`=1, then goes to MEM_WB.
  - MEM_WB:
    - Outputs: result_src=01, reg_write=1, instr_done=1.
    - Next state: FETCH.
  - MEM_WRITE:
    - Outputs: adr_src=1, mem_write=1.
    - Holds until `mem_ready`=1; in that cycle instr_done=1 and the next state is FETCH.
  - EXEC_R:
    - Outputs: a=10, b=00.
    - alu_control from funct3: 000 → sub if funct7_5=1, else add; 111 and; 110 or; 100 xor; 010 slt.
    - Next state: ALU_WB.
  - EXEC_I:
    - Outputs: a=10, b=01.
    - alu_control uses the same funct3 map, but funct7_5 is ignored (addi is always add).
    - Next state: ALU_WB.
  - ALU_WB:
    - Outputs: result_src=00, reg_write=1, instr_done=1.
    - Next state: FETCH.
  - BEQ:
    - Outputs: a=10, b=00, sub, result_src=00, pc_write=`zero`, instr_done=1.
    - Next state: FETCH.
  - JAL:
    - Outputs: a=01, b=10, add, result_src=00, pc_write=1. PC ← target; ALU computes old PC+4.
    - Next state: ALU_WB, which writes rd = old PC+4.
  - TRAP:
    - Outputs: illegal_instr=1, all enables 0.
    - Leaves TRAP only on reset.
- Latency in cycles with zero memory wait: lw 5, sw 4, R/I 4, beq 3, jal 4. Each `mem_ready`=0 cycle adds one cycle.
- Reset mid-instruction: async return to FETCH; no partial write is completed.
- `mem_read` and `mem_write` are never high in the same cycle.

Decomposition:
- riscv_ctrl_pkg: opcode constants, state encodings, ALU control codes, and the select encodings for result/A/B/adr.
- Sub-module alu_decoder: combinational mapping of (funct3, funct7_5, is_rtype) → (alu_control, funct_illegal); used by both EXEC_R/EXEC_I and DECODE.

Test Plan:
- Reset: `rst_n`=0 mid-DECODE → state=0 immediately, all enables 0. Release with opcode=0110011 and `mem_ready`=1 → FETCH asserts pc_write=1, ir_write=1, alu_src_b=10.
- add then sub: funct3=000 with funct7_5=0, then funct7_5=1 → state sequence 0,1,6,8,0; alu_control=000, then 001; reg_write=1 only in ALU_WB; instr_done pulses once per instruction.
- lw with `mem_ready` held 0 for 3 cycles in MEM_READ → stays in state 3 for 4 cycles with adr_src=1; MEM_WB has result_src=01; total 8 cycles.
- sw → states 0,1,2,5; mem_write=1 and reg_write=0 throughout; returns to FETCH after `mem_ready`.
- beq with zero=1 versus zero=0 → pc_write=1 versus 0 in state 9. jal → pc_write=1 in state 10, then ALU_WB writes with result_src=00.
- Illegal opcode 1111111, or R-type funct3=001 → state=11, illegal_instr=1, held for 20 cycles. With TRAP_ON_ILLEGAL=0 → returns to FETCH with no writes.
